// File: rtl/v_pkg.sv
// Shared types for the v_pipe_update front end.
// Holds the update-bus field types and the arbiter FSM encoding.
package v_pkg;

  typedef logic [2:0]  id_t;
  typedef logic [1:0]  cmd_t;
  typedef logic [15:0] key_t;
  typedef logic [7:0]  size_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    QUIESCED = 2'd2
  } upd_arb_state_t;

  localparam int UPD_ARB_STATS_W = 16;

endpackage

// File: rtl/v_rr_arb.sv
// Combinational round-robin picker: first request at or above the
// pointer, wrapping, plus the pointer that follows the winner.
module v_rr_arb #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_nxt_ptr
);

  logic          w_found;
  int            w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_gnt     = '0;
    o_nxt_ptr = i_ptr;
    w_found   = 1'b0;
    w_sum     = 0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = PW'(w_sum);
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_nxt_ptr    = (w_sum == N - 1) ? '0 : PW'(w_sum + 1);
      end
    end
  end

endmodule

// File: rtl/v_upd_arb.sv
// Round-robin scheduler for the v_pipe_update bus with RMW hazard
// blocking and quiesce/drain. Optional stats: V_UPD_ARB_STATS_EN.
module v_upd_arb
  import v_pkg::*;
#(
  parameter int N_PROD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PROD-1:0]       i_req_vld,
  input  cmd_t  [N_PROD-1:0]      i_req_cmd,
  input  key_t  [N_PROD-1:0]      i_req_key,
  input  size_t [N_PROD-1:0]      i_req_size,
  output logic [N_PROD-1:0]       o_req_ack,
  output logic                    o_upd_vld_r,
  output id_t                     o_upd_prod_id_r,
  output cmd_t                    o_upd_cmd_r,
  output key_t                    o_upd_key_r,
  output size_t                   o_upd_size_r,
  input  logic                    i_s1_upd_vld_r,
  input  logic                    i_s2_upd_vld_r,
  input  logic                    i_s3_upd_vld_r,
  input  logic                    i_s4_upd_vld_r,
  input  id_t                     i_s1_upd_prod_id_r,
  input  id_t                     i_s2_upd_prod_id_r,
  input  id_t                     i_s3_upd_prod_id_r,
  input  id_t                     i_s4_upd_prod_id_r,
  input  logic                    i_quiesce_req,
  output logic                    o_quiesce_ack_r,
  output logic [1:0]              o_state_r
`ifdef V_UPD_ARB_STATS_EN
  ,
  input  logic                    i_stats_clr,
  output logic [N_PROD-1:0][UPD_ARB_STATS_W-1:0] o_grant_cnt_r,
  output logic [N_PROD-1:0][UPD_ARB_STATS_W-1:0] o_block_cnt_r
`endif
);

  localparam int PW = $clog2(N_PROD);

  upd_arb_state_t    r_state;
  upd_arb_state_t    w_state_nxt;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     w_nxt_ptr;
  logic [N_PROD-1:0] w_hz;
  logic [N_PROD-1:0] w_elig;
  logic [N_PROD-1:0] w_gnt;
  logic              w_run;
  logic              w_empty;
  id_t               w_gid;
  cmd_t              w_cmd;
  key_t              w_key;
  size_t             w_size;

  // A producer with anything in flight must not issue again (RMW).
  for (genvar g = 0; g < N_PROD; g++) begin : g_hz
    localparam id_t ID = id_t'(g);
    assign w_hz[g] =
      (o_upd_vld_r    && o_upd_prod_id_r    == ID) ||
      (i_s1_upd_vld_r && i_s1_upd_prod_id_r == ID) ||
      (i_s2_upd_vld_r && i_s2_upd_prod_id_r == ID) ||
      (i_s3_upd_vld_r && i_s3_upd_prod_id_r == ID) ||
      (i_s4_upd_vld_r && i_s4_upd_prod_id_r == ID);
  end

  assign w_run   = (r_state == RUN) && !i_quiesce_req;
  assign w_elig  = i_req_vld & ~w_hz & {N_PROD{w_run}};
  assign w_empty = !(o_upd_vld_r | i_s1_upd_vld_r | i_s2_upd_vld_r |
                     i_s3_upd_vld_r | i_s4_upd_vld_r);

  v_rr_arb #(.N(N_PROD)) u_rr (
    .i_req     (w_elig),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_nxt_ptr (w_nxt_ptr)
  );

  assign o_req_ack = w_gnt;
  assign o_state_r = r_state;

  always_comb begin
    w_gid  = '0;
    w_cmd  = '0;
    w_key  = '0;
    w_size = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (w_gnt[i]) begin
        w_gid  = id_t'(i);
        w_cmd  = i_req_cmd[i];
        w_key  = i_req_key[i];
        w_size = i_req_size[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (i_quiesce_req) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!i_quiesce_req) w_state_nxt = RUN;
        else if (w_empty)   w_state_nxt = QUIESCED;
      end
      QUIESCED: if (!i_quiesce_req) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= RUN;
      r_ptr           <= '0;
      o_quiesce_ack_r <= 1'b0;
      o_upd_vld_r     <= 1'b0;
      o_upd_prod_id_r <= '0;
      o_upd_cmd_r     <= '0;
      o_upd_key_r     <= '0;
      o_upd_size_r    <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_ptr           <= w_nxt_ptr;
      o_quiesce_ack_r <= (w_state_nxt == QUIESCED);
      o_upd_vld_r     <= |w_gnt;
      if (|w_gnt) begin
        o_upd_prod_id_r <= w_gid;
        o_upd_cmd_r     <= w_cmd;
        o_upd_key_r     <= w_key;
        o_upd_size_r    <= w_size;
      end
    end
  end

`ifdef V_UPD_ARB_STATS_EN
  localparam logic [UPD_ARB_STATS_W-1:0] SAT = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_grant_cnt_r <= '0;
      o_block_cnt_r <= '0;
    end else if (i_stats_clr) begin
      o_grant_cnt_r <= '0;
      o_block_cnt_r <= '0;
    end else begin
      for (int i = 0; i < N_PROD; i++) begin
        if (w_gnt[i] && o_grant_cnt_r[i] != SAT)
          o_grant_cnt_r[i] <= o_grant_cnt_r[i] + 1'b1;
        if (i_req_vld[i] && w_hz[i] && o_block_cnt_r[i] != SAT)
          o_block_cnt_r[i] <= o_block_cnt_r[i] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_v_upd_arb.sv
// Self-checking bench for v_upd_arb: vector table, directed
// multi-cycle sequences and a randomized run against a timing model.
module tb_v_upd_arb;
  import v_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_vld = '0;
  logic [3:0][1:0]  req_cmd = '0;
  logic [3:0][15:0] req_key = '0;
  logic [3:0][7:0]  req_size = '0;
  logic [3:0]       ack;
  logic             upd_vld;
  id_t              upd_id;
  cmd_t             upd_cmd;
  key_t             upd_key;
  size_t            upd_size;
  logic             q = 1'b0;
  logic             qack;
  logic [1:0]       state;

  logic             pipe_auto = 1'b1;
  logic [4:1]       p_vld;
  id_t              p_id [4:1];
  logic [4:1]       f_vld = '0;
  id_t              f_id [4:1];
  logic [4:1]       s_vld;
  id_t              s_id [4:1];

  int total = 0;
  int bad   = 0;

`ifdef V_UPD_ARB_STATS_EN
  logic             stats_clr = 1'b0;
  logic [3:0][15:0] gcnt;
  logic [3:0][15:0] bcnt;
`endif

  always #5 clk = ~clk;

  // Four-stage pipeline stand-in fed by the update bus.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_vld <= '0;
      for (int k = 1; k <= 4; k++) p_id[k] <= '0;
    end else begin
      p_vld   <= {p_vld[3:1], upd_vld};
      p_id[1] <= upd_id;
      for (int k = 2; k <= 4; k++) p_id[k] <= p_id[k-1];
    end
  end

  always_comb begin
    for (int k = 1; k <= 4; k++) begin
      s_vld[k] = pipe_auto ? p_vld[k] : f_vld[k];
      s_id[k]  = pipe_auto ? p_id[k]  : f_id[k];
    end
  end

  v_upd_arb #(.N_PROD(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_req_vld          (req_vld),
    .i_req_cmd          (req_cmd),
    .i_req_key          (req_key),
    .i_req_size         (req_size),
    .o_req_ack          (ack),
    .o_upd_vld_r        (upd_vld),
    .o_upd_prod_id_r    (upd_id),
    .o_upd_cmd_r        (upd_cmd),
    .o_upd_key_r        (upd_key),
    .o_upd_size_r       (upd_size),
    .i_s1_upd_vld_r     (s_vld[1]),
    .i_s2_upd_vld_r     (s_vld[2]),
    .i_s3_upd_vld_r     (s_vld[3]),
    .i_s4_upd_vld_r     (s_vld[4]),
    .i_s1_upd_prod_id_r (s_id[1]),
    .i_s2_upd_prod_id_r (s_id[2]),
    .i_s3_upd_prod_id_r (s_id[3]),
    .i_s4_upd_prod_id_r (s_id[4]),
    .i_quiesce_req      (q),
    .o_quiesce_ack_r    (qack),
    .o_state_r          (state)
`ifdef V_UPD_ARB_STATS_EN
    ,
    .i_stats_clr        (stats_clr),
    .o_grant_cnt_r      (gcnt),
    .o_block_cnt_r      (bcnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {upd_vld, upd_id, upd_cmd, upd_key, upd_size, qack, state};
  endfunction

  task automatic do_reset();
    req_vld = '0;
    q       = 1'b0;
    f_vld   = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_outs", outs(), 32'h0);
    chk("reset_ack", {28'h0, ack}, 32'h0);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0]      vld;
    logic            q;
    logic [3:0]      svld;
    logic [3:0][2:0] sid;
    logic [3:0]      ack;
    logic            uvld;
    logic [2:0]      uid;
    logic [1:0]      st;
  } vec_t;

  vec_t tbl [13];

  // Random-run model state
  int   m_ptr, m_mode, m_last_any, t;
  int   m_last [4];
  logic [3:0] pend;
  logic m_vld;
  logic [2:0] m_id;
  logic [25:0] m_pay;
  int   m_g;
  logic [3:0] m_ack;
  int   m_gcnt [4];

  initial begin
    for (int k = 1; k <= 4; k++) f_id[k] = '0;
    for (int i = 0; i < 4; i++) begin
      req_key[i]  = 16'hA000 + 16'(i);
      req_size[i] = 8'(i + 1);
      req_cmd[i]  = 2'(i);
    end

    //         vld     q     svld    sid     ack     uv    uid   st
    tbl[0]  = {4'b1111, 1'b0, 4'b0000, 12'h000, 4'b0001, 1'b0, 3'd0, 2'd0};
    tbl[1]  = {4'b1111, 1'b0, 4'b0000, 12'h000, 4'b0010, 1'b1, 3'd0, 2'd0};
    tbl[2]  = {4'b1111, 1'b0, 4'b0000, 12'h000, 4'b0100, 1'b1, 3'd1, 2'd0};
    tbl[3]  = {4'b1111, 1'b0, 4'b0000, 12'h000, 4'b1000, 1'b1, 3'd2, 2'd0};
    tbl[4]  = {4'b1111, 1'b0, 4'b0100, 12'h000, 4'b0010, 1'b1, 3'd3, 2'd0};
    tbl[5]  = {4'b0000, 1'b0, 4'b0000, 12'h000, 4'b0000, 1'b1, 3'd1, 2'd0};
    tbl[6]  = {4'b0001, 1'b0, 4'b0000, 12'h000, 4'b0001, 1'b0, 3'd1, 2'd0};
    tbl[7]  = {4'b1010, 1'b0, 4'b0100, 12'h040, 4'b1000, 1'b1, 3'd0, 2'd0};
    tbl[8]  = {4'b0001, 1'b0, 4'b0000, 12'h000, 4'b0001, 1'b1, 3'd3, 2'd0};
    tbl[9]  = {4'b0011, 1'b0, 4'b0001, 12'h001, 4'b0000, 1'b1, 3'd0, 2'd0};
    tbl[10] = {4'b0010, 1'b1, 4'b0000, 12'h000, 4'b0000, 1'b0, 3'd0, 2'd0};
    tbl[11] = {4'b0010, 1'b0, 4'b0000, 12'h000, 4'b0000, 1'b0, 3'd0, 2'd1};
    tbl[12] = {4'b0010, 1'b0, 4'b0000, 12'h000, 4'b0010, 1'b0, 3'd0, 2'd0};

    // Vector table with forced pipeline stages
    pipe_auto = 1'b0;
    do_reset();
    for (int r = 0; r < 13; r++) begin
      @(negedge clk);
      req_vld = tbl[r].vld;
      q       = tbl[r].q;
      for (int k = 0; k < 4; k++) begin
        f_vld[k+1] = tbl[r].svld[k];
        f_id[k+1]  = tbl[r].sid[k];
      end
      #1;
      chk($sformatf("tbl%0d_ack", r), {28'h0, ack}, {28'h0, tbl[r].ack});
      chk($sformatf("tbl%0d_uvld", r), {31'h0, upd_vld}, {31'h0, tbl[r].uvld});
      chk($sformatf("tbl%0d_uid", r), {29'h0, upd_id}, {29'h0, tbl[r].uid});
      chk($sformatf("tbl%0d_st", r), {30'h0, state}, {30'h0, tbl[r].st});
      chk($sformatf("tbl%0d_qack", r), {31'h0, qack}, 32'h0);
    end
    pipe_auto = 1'b1;

    // Single producer held valid: one issue per 6 cycles
    do_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      req_vld = 4'b0100;
      #1;
      chk($sformatf("solo_ack%0d", c), {28'h0, ack},
          (c % 6 == 0) ? 32'h4 : 32'h0);
      chk($sformatf("solo_uvld%0d", c), {31'h0, upd_vld},
          (c % 6 == 1) ? 32'h1 : 32'h0);
    end

    // Quiesce after two issues
    do_reset();
    @(negedge clk);
    req_vld = 4'b0011;
    #1 chk("q_ack0", {28'h0, ack}, 32'h1);
    @(negedge clk);
    req_vld = 4'b0010;
    #1 chk("q_ack1", {28'h0, ack}, 32'h2);
    for (int c = 2; c < 12; c++) begin
      @(negedge clk);
      req_vld = 4'b1100;
      q       = 1'b1;
      #1;
      chk($sformatf("q_gnt%0d", c), {28'h0, ack}, 32'h0);
      chk($sformatf("q_qack%0d", c), {31'h0, qack},
          (c >= 8) ? 32'h1 : 32'h0);
      chk($sformatf("q_st%0d", c), {30'h0, state},
          (c == 2) ? 32'd0 : (c < 8) ? 32'd1 : 32'd2);
    end
    @(negedge clk);
    q = 1'b0;
    #1;
    chk("q_rel_st", {30'h0, state}, 32'd2);
    chk("q_rel_qack", {31'h0, qack}, 32'h1);
    chk("q_rel_ack", {28'h0, ack}, 32'h0);
    @(negedge clk);
    #1;
    chk("q_run_st", {30'h0, state}, 32'd0);
    chk("q_run_qack", {31'h0, qack}, 32'h0);
    chk("q_run_ack", {28'h0, ack}, 32'h4);

    // Reset while draining with s2 occupied
    do_reset();
    @(negedge clk);
    req_vld = 4'b0001;
    #1 chk("rd_ack0", {28'h0, ack}, 32'h1);
    @(negedge clk);
    req_vld = 4'b0000;
    q       = 1'b1;
    @(negedge clk);
    #1 chk("rd_st2", {30'h0, state}, 32'd1);
    @(negedge clk);
    #1;
    chk("rd_s2", {31'h0, s_vld[2]}, 32'h1);
    chk("rd_st3", {30'h0, state}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rd_outs", outs(), 32'h0);
    chk("rd_ack", {28'h0, ack}, 32'h0);
    q = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized run against the timing model
    do_reset();
    m_ptr = 0; m_mode = 0; m_last_any = -100;
    m_vld = 1'b0; m_id = '0; m_pay = '0; pend = '0;
    for (int i = 0; i < 4; i++) begin
      m_last[i] = -100;
      m_gcnt[i] = 0;
    end
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          if ($urandom_range(15) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          pend[i]     = 1'b1;
          req_cmd[i]  = 2'($urandom);
          req_key[i]  = 16'($urandom);
          req_size[i] = 8'($urandom);
        end
      end
      req_vld = pend;
      if ($urandom_range(39) == 0) q = ~q;
      #1;
      m_g = -1;
      if (m_mode == 0 && !q)
        for (int k = 0; k < 4; k++) begin
          int i;
          i = (m_ptr + k) % 4;
          if (m_g < 0 && pend[i] && (t - m_last[i]) > 5) m_g = i;
        end
      m_ack = (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
      chk("rnd_ack", {28'h0, ack}, {28'h0, m_ack});
      chk("rnd_uvld", {31'h0, upd_vld}, {31'h0, m_vld});
      chk("rnd_bus", {3'h0, upd_id, upd_cmd, upd_key, upd_size},
          {3'h0, m_id, m_pay});
      chk("rnd_st", {30'h0, state}, m_mode);
      chk("rnd_qack", {31'h0, qack}, (m_mode == 2) ? 32'h1 : 32'h0);
      case (m_mode)
        0: if (q) m_mode = 1;
        1: if (!q) m_mode = 0;
           else if (t - m_last_any > 5) m_mode = 2;
        default: if (!q) m_mode = 0;
      endcase
      m_vld = (m_g >= 0);
      if (m_g >= 0) begin
        m_id        = 3'(m_g);
        m_pay       = {req_cmd[m_g], req_key[m_g], req_size[m_g]};
        m_last[m_g] = t;
        m_last_any  = t;
        m_ptr       = (m_g + 1) % 4;
        pend[m_g]   = 1'b0;
        m_gcnt[m_g]++;
      end
    end

`ifdef V_UPD_ARB_STATS_EN
    @(negedge clk);
    req_vld = '0;
    q = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("gcnt%0d", i), {16'h0, gcnt[i]}, 32'(m_gcnt[i]));
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("gcnt_clr", {16'h0, gcnt[0]}, 32'h0);
    chk("bcnt_clr", {16'h0, bcnt[0]}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/v_upd_arb.md
Name: v_upd_arb

Overview:
- Round-robin arbiter and scheduler in front of the v_pipe_update list-update pipeline.
- Shares the single update bus (upd_vld/prod_id/cmd/key/size) between N_PROD producer requesters.
- Blocks any producer that already has an update in flight in the pipeline (read-modify-write hazard).
- Provides a quiesce handshake that stops issue and drains the pipeline before state is reconfigured or inspected.

Parameters:
- N_PROD, 4, number of requesters; requester i always issues prod_id = i; 2 <= N_PROD <= 2**$bits(v_pkg::id_t).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_req_vld  in  N_PROD  per-requester request valid
- i_req_cmd  in  N_PROD x $bits(v_pkg::cmd_t)  per-requester command
- i_req_key  in  N_PROD x $bits(v_pkg::key_t)  per-requester key
- i_req_size  in  N_PROD x $bits(v_pkg::size_t)  per-requester size
- o_req_ack  out  N_PROD  one-hot grant/accept, combinational
- o_upd_vld_r  out  1  update bus valid, to v_pipe_update i_upd_vld
- o_upd_prod_id_r  out  v_pkg::id_t  granted producer id
- o_upd_cmd_r / o_upd_key_r / o_upd_size_r  out  cmd_t/key_t/size_t  granted payload
- i_s1_upd_vld_r .. i_s4_upd_vld_r  in  1 each  pipeline stage valid (from v_pipe_update)
- i_s1_upd_prod_id_r .. i_s4_upd_prod_id_r  in  v_pkg::id_t each  pipeline stage producer id
- i_quiesce_req  in  1  level request to stop issue and drain
- o_quiesce_ack_r  out  1  pipeline empty and issue halted
- o_state_r  out  2  current FSM state, debug

Behaviour:
- Reset (async, rst=1): all outputs 0; round-robin pointer 0; FSM in RUN. Payload registers are also cleared.
- Handshake:
  - Requester holds vld and payload stable until it sees ack.
  - Ack is a single-cycle pulse in cycle T; the payload appears on o_upd_* in T+1, so latency is 1 cycle.
  - Requests that are dropped before ack are legal and have no effect.
- Eligibility: requester i is eligible iff i_req_vld[i] and no hazard and FSM==RUN and i_quiesce_req==0.
- Hazard for i: any of {o_upd_vld_r, i_s1..i_s4_upd_vld_r} is 1 with matching prod_id == i.
  - Therefore the same producer can issue at most once per 6 cycles.
- Grant: first eligible index searched from the pointer upward, wrapping N_PROD-1 -> 0. At most one grant per cycle.
- Pointer: after a grant to index g, pointer = (g+1) mod N_PROD. It is unchanged if there is no grant.
- Bus register: o_upd_vld_r <= |o_req_ack every cycle. Payload and prod_id load only on a grant and hold otherwise.
- FSM (registered, encoding RUN=0, DRAIN=1, QUIESCED=2):
  - RUN -> DRAIN when i_quiesce_req=1. Grants are already suppressed in that same cycle.
  - DRAIN -> QUIESCED when o_upd_vld_r and all s1..s4 vld are 0. o_quiesce_ack_r=1 from the QUIESCED entry cycle.
  - DRAIN -> RUN if i_quiesce_req drops before empty; no ack is given.
  - QUIESCED -> RUN when i_quiesce_req=0. Ack drops in the same transition; grants resume the cycle after.
  - Encoding 3 is illegal and recovers to RUN.
- Boundaries:
  - Hazard and round-robin interact: a blocked pointer target is skipped and does not hold the pointer.
  - Pipeline already empty on a quiesce request: DRAIN lasts exactly 1 cycle.
  - Reset during DRAIN or QUIESCED returns to RUN. Un-acked requests must be re-presented by the requester.

Optional Feature:
- Macro: V_UPD_ARB_STATS_EN.
- Defined:
  - Adds output o_grant_cnt_r (N_PROD x 16): per-requester saturating grant counters that stick at 16'hFFFF.
  - Adds output o_block_cnt_r (N_PROD x 16): per-requester saturating counters of cycles where the requester was valid but hazard-blocked.
  - Adds input i_stats_clr: synchronous clear of both counters, taking priority over increment.
  - Async reset clears both counters to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- In v_pkg:
  - upd_arb_state_t enum {RUN, DRAIN, QUIESCED}.
  - UPD_ARB_STATS_W = 16.
  - Reuse the existing id_t, cmd_t, key_t, size_t.
- Sub-module v_rr_arb (parameter N):
  - Inputs: request mask and pointer.
  - Outputs: one-hot grant and next pointer.
  - Purely combinational; the pointer flop stays in v_upd_arb.
- Hazard compare: inline in v_upd_arb.

Test Plan:
- All 4 requesters valid from cycle 0, pipeline idle -> acks 0,1,2,3 in cycles 0..3; o_upd_prod_id_r = 0,1,2,3 in cycles 1..4; pointer wraps to 0.
- Requester 2 held valid continuously, others idle -> acks at cycles 0, 6, 12 (5-cycle hazard gap); o_upd_vld_r high at 1, 7, 13.
- Pointer=1, req1 blocked by i_s3 prod_id=1, req3 valid -> ack[3], pointer -> 0.
- Issue 2 updates, then assert i_quiesce_req one cycle later -> no further acks; o_quiesce_ack_r rises once s4 of the last update is empty; deassert req -> ack falls and grants resume the next cycle.
- Assert rst mid-DRAIN with s2 valid -> all outputs 0 immediately; o_state_r=RUN.
- With V_UPD_ARB_STATS_EN: 70000 grants to requester 0 -> o_grant_cnt_r[0]=16'hFFFF; i_stats_clr -> 0 the next cycle.
